// File: rtl/mux4_arb_pkg.sv
// Shared types and constants for the 4-requester round-robin arbiter.
// No logic; no latency; no flow control.
// Imported by the picker and the arbiter top.
package mux4_arb_pkg;

   localparam int NUM_REQ = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   typedef logic [1:0] owner_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request at or after ptr.
// Latency: zero (pure combinational).
// No backpressure; found=0 when no request is set.
module rr_pick4
   import mux4_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  owner_t             ptr,
   output logic               found,
   output owner_t             idx
);

   owner_t cand;

   // Walk from the farthest offset down so the closest match to ptr wins.
   always_comb begin
      found = 1'b0;
      idx   = ptr;
      cand  = ptr;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         cand = ptr + owner_t'(i);
         if (req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for 4 requesters with bounded hold and a shared 4:1 data mux.
// Latency: 1 cycle req-to-gnt, 1 cycle din-to-y.
// Owner keeps the grant while req is held, up to HOLD_MAX cycles when others wait.
module mux4_rr_arbiter
   import mux4_arb_pkg::*;
#(
   parameter int HOLD_MAX = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] din,
   output logic [NUM_REQ-1:0] gnt,
   output owner_t             sel,
   output logic               valid,
   output logic               y
);

   localparam int                CNT_W   = $clog2(HOLD_MAX);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(HOLD_MAX - 1);

   state_t           state;
   owner_t           ptr;
   logic [CNT_W-1:0] hold_cnt;

   logic   own_req;
   logic   others;
   logic   rotate;
   owner_t pick_ptr;
   logic   found;
   owner_t pick_idx;
   logic   din_sel;

   assign own_req = req[sel];
   assign others  = |(req & ~gnt);
   assign din_sel = din[sel];

   // Release or forced rotation moves the search origin past the current owner this cycle,
   // so the successor is granted on the very next edge.
   assign rotate   = (state == GRANT) && (!own_req || (others && (hold_cnt == CNT_MAX)));
   assign pick_ptr = rotate ? owner_t'(sel + 2'd1) : ptr;

   rr_pick4 u_pick (
      .req   (req),
      .ptr   (pick_ptr),
      .found (found),
      .idx   (pick_idx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         gnt      <= '0;
         sel      <= '0;
         valid    <= 1'b0;
         y        <= 1'b0;
         ptr      <= '0;
         hold_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               y <= 1'b0;
               if (found) begin
                  state    <= GRANT;
                  sel      <= pick_idx;
                  gnt      <= NUM_REQ'(1) << pick_idx;
                  valid    <= 1'b1;
                  hold_cnt <= '0;
               end else begin
                  gnt   <= '0;
                  valid <= 1'b0;
               end
            end
            GRANT: begin
               if (rotate) begin
                  ptr <= owner_t'(sel + 2'd1);
                  if (found) begin
                     sel      <= pick_idx;
                     gnt      <= NUM_REQ'(1) << pick_idx;
                     hold_cnt <= '0;
                     y        <= din_sel;
                  end else begin
                     state <= IDLE;
                     gnt   <= '0;
                     valid <= 1'b0;
                     y     <= 1'b0;
                  end
               end else begin
                  if (hold_cnt != CNT_MAX) begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
                  y <= din_sel;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_mux4_rr_arbiter;

   localparam int HOLD_MAX = 8;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req   = 4'd0;
   logic [3:0] din   = 4'd0;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       valid;
   logic       y;

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model: owner (-1 = none), search origin, cycles granted so far.
   int   m_owner = -1;
   int   m_ptr   = 0;
   int   m_held  = 0;
   int   m_sel   = 0;
   logic m_y     = 1'b0;

   mux4_rr_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .din   (din),
      .gnt   (gnt),
      .sel   (sel),
      .valid (valid),
      .y     (y)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [3:0] r, input int p);
      for (int i = 0; i < 4; i++) begin
         if (r[(p + i) % 4]) return (p + i) % 4;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
      m_sel   = 0;
      m_y     = 1'b0;
   endtask

   task automatic model_step(input logic [3:0] r, input logic [3:0] d);
      int       old_owner;
      logic [3:0] others;
      old_owner = m_owner;
      if (m_owner < 0) begin
         if (r != 4'd0) begin
            m_owner = pick(r, m_ptr);
            m_held  = 1;
         end
      end else begin
         others = r & ~(4'd1 << m_owner);
         if (!r[m_owner] || (others != 4'd0 && m_held >= HOLD_MAX)) begin
            m_ptr   = (m_owner + 1) % 4;
            m_owner = pick(r, m_ptr);
            m_held  = 1;
         end else begin
            m_held++;
         end
      end
      if (m_owner >= 0) m_sel = m_owner;
      m_y = (m_owner >= 0 && old_owner >= 0) ? d[old_owner] : 1'b0;
   endtask

   task automatic check_all(input string tag);
      logic [3:0] exp_gnt;
      exp_gnt = (m_owner >= 0) ? (4'd1 << m_owner) : 4'd0;
      chk({tag, "_gnt"},    32'(gnt), 32'(exp_gnt));
      chk({tag, "_sel"},    32'(sel), 32'(m_sel));
      chk({tag, "_valid"},  32'(valid), 32'(m_owner >= 0));
      chk({tag, "_y"},      32'(y), 32'(m_y));
      chk({tag, "_onehot"}, 32'($countones(gnt) > 1), 32'd0);
      chk({tag, "_gsel"},   32'(gnt[sel]), 32'(valid));
   endtask

   task automatic step(input logic [3:0] r, input logic [3:0] d, input string tag);
      req = r;
      din = d;
      @(posedge clk);
      model_step(r, d);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("rst");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [3:0] cur_req;

   initial begin
      // Power-on reset.
      req = 4'd0;
      do_reset();

      // Single requester 2: grant after one edge, y lags din[2] by one cycle.
      step(4'b0100, 4'($urandom), "r26");
      chk("r26_sel_first", 32'(sel), 32'd2);
      chk("r26_gnt_first", 32'(gnt), 32'h4);
      for (int i = 0; i < 5; i++) step(4'b0100, 4'($urandom), "r26");

      // All requesting: each owner holds exactly HOLD_MAX cycles, no gaps.
      do_reset();
      for (int i = 0; i < 5 * HOLD_MAX; i++) begin
         step(4'b1111, 4'($urandom), "r27");
         chk("r27_seq", 32'(gnt), 32'(4'd1 << ((i / HOLD_MAX) % 4)));
      end

      // Owner 1 releases with 3 waiting, then 3 releases and ptr wraps to 0.
      do_reset();
      step(4'b0010, 4'($urandom), "r28");
      step(4'b0010, 4'($urandom), "r28");
      step(4'b1010, 4'($urandom), "r28");
      step(4'b1010, 4'($urandom), "r28");
      step(4'b1000, 4'($urandom), "r28");
      chk("r28_handoff", 32'(gnt), 32'h8);
      step(4'b1000, 4'($urandom), "r28");
      step(4'b0000, 4'($urandom), "r28");
      chk("r28_idle", 32'(valid), 32'd0);
      step(4'b1010, 4'($urandom), "r28");
      chk("r28_ptr0", 32'(gnt), 32'h2);

      // Lone requester keeps the grant well past HOLD_MAX.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         step(4'b0100, 4'($urandom), "r29");
         chk("r29_hold", 32'(gnt), 32'h4);
      end
      step(4'b0000, 4'hF, "r29");
      chk("r29_drop_gnt", 32'(gnt), 32'd0);
      chk("r29_drop_y",   32'(y), 32'd0);

      // Reset during an owner-3 grant, with ptr previously moved off 0.
      do_reset();
      step(4'b0100, 4'($urandom), "r30");
      step(4'b0000, 4'($urandom), "r30");
      step(4'b1000, 4'($urandom), "r30");
      step(4'b1000, 4'($urandom), "r30");
      step(4'b1000, 4'($urandom), "r30");
      do_reset();
      chk("r30_gnt",   32'(gnt), 32'd0);
      chk("r30_sel",   32'(sel), 32'd0);
      chk("r30_valid", 32'(valid), 32'd0);
      step(4'b1010, 4'($urandom), "r30");
      chk("r30_first", 32'(gnt), 32'h2);

      // Random traffic: request patterns held for random stretches, din random every cycle.
      do_reset();
      cur_req = 4'd0;
      for (int i = 0; i < 10000; i++) begin
         case ($urandom_range(15))
            0, 1:    cur_req = 4'($urandom);
            2:       cur_req = cur_req ^ (4'd1 << $urandom_range(3));
            3:       cur_req = 4'd1 << $urandom_range(3);
            default: cur_req = cur_req;
         endcase
         step(cur_req, 4'($urandom), "rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
